// File: rtl/decoder_pkg.sv
// Shared types and constants for the sequenced 3-to-8 decoder.
package decoder_pkg;

    localparam int unsigned LINES  = 8;
    localparam int unsigned CODE_W = 3;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StActive = 2'b01,
        StGap    = 2'b10
    } state_e;

    // Pulse/gap counter width: clog2(max(pulse_w, gap_w, 2)).
    function automatic int unsigned cnt_width(input int unsigned pulse_w,
                                              input int unsigned gap_w);
        int unsigned m;
        m = (pulse_w > gap_w) ? pulse_w : gap_w;
        if (m < 2) begin
            m = 2;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/decoder_3x8.sv
// Combinational 3-bit to 8-bit one-hot decoder core with enable.
module decoder_3x8
    import decoder_pkg::*;
(
    input  logic [CODE_W-1:0] code,
    input  logic              en,
    output logic [LINES-1:0]  lines
);

    always_comb begin
        lines = '0;
        if (en) begin
            lines[code] = 1'b1;
        end
    end

endmodule

// File: rtl/decoder_3x8_seq.sv
// Sequenced 3-to-8 decoder: accepts a code over valid/ready, pulses the matching
// one-hot line for PULSE_W cycles, idles GAP_W cycles, and counts accepted codes.
module decoder_3x8_seq
    import decoder_pkg::*;
#(
    parameter int unsigned PULSE_W = 4,
    parameter int unsigned GAP_W   = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code,
    output logic [LINES-1:0]  out,
    output logic              busy,
    output logic              done,
    input  logic              clear,
    output logic [CNT_W-1:0]  dec_count
);

    localparam int unsigned CW = cnt_width(PULSE_W, GAP_W);
    localparam logic [CW-1:0] PulseLoad = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GapLoad   = (GAP_W > 0) ? CW'(GAP_W - 1) : '0;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic [CNT_W-1:0]    dec_count_q, dec_count_d;
    logic [LINES-1:0]    out_q, out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                accept;

    assign in_ready = (state_q == StIdle) && rst_n;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    code_d  = code;
                    cnt_d   = PulseLoad;
                    state_d = StActive;
                end
            end
            StActive: begin
                if (cnt_q == '0) begin
                    if (GAP_W > 0) begin
                        cnt_d   = GapLoad;
                        state_d = StGap;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        dec_count_d = dec_count_q;
        if (clear) begin
            dec_count_d = '0;
        end else if (accept && !(&dec_count_q)) begin
            dec_count_d = dec_count_q + CNT_W'(1);
        end
    end

    // Outputs are flopped, so they are decoded from next-state values.
    decoder_3x8 u_core (
        .code  (code_d),
        .en    (state_d == StActive),
        .lines (out_d)
    );

    assign busy_d = (state_d != StIdle);
    assign done_d = (state_d == StActive) && (cnt_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            code_q      <= '0;
            dec_count_q <= '0;
            out_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            dec_count_q <= dec_count_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out       = out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dec_count = dec_count_q;

endmodule

// File: doc/decoder_3x8_seq.md
# decoder_3x8_seq

Sequenced 3-to-8 decoder: accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line for a programmable pulse width, followed by a programmable idle gap. It is the receive-side counterpart of the 8-to-3 encoder in the ALU-basics library and drives select/strobe lines from a compact binary code. A saturating counter tracks how many codes have been decoded.

## Interface
- PULSE_W, 4, cycles each one-hot output stays asserted; legal range ≥1
- GAP_W, 1, all-zero cycles forced after each pulse before the next accept; legal range ≥0
- CNT_W, 8, width of the decode counter
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  code is presented
- in_ready  output  1  block can accept a code this cycle
- code  input  3  binary line index 0..7
- out  output  8  one-hot decoded lines, out[i] for code i
- busy  output  1  high in ACTIVE or GAP
- done  output  1  one-cycle pulse on the last ACTIVE cycle
- clear  input  1  synchronous clear of dec_count
- dec_count  output  CNT_W  accepted-code count, saturating

## Operation
- States: IDLE, ACTIVE, GAP.
- IDLE: in_ready=1, out=0, busy=0. Accept when in_valid&&in_ready: latch code, load pulse counter with PULSE_W-1, go to ACTIVE.
- ACTIVE: out = 8'b1 << latched code; counter decrements; when counter==0 assert done, then go to GAP (load GAP_W-1) if GAP_W>0, else IDLE.
- GAP: out=0; counter decrements; at 0 go to IDLE.
- in_ready = (state==IDLE) && rst_n; no combinational path from in_valid or code to any output.
- code is sampled only at acceptance; changes to code/in_valid in ACTIVE/GAP are ignored.
- out is always one-hot in ACTIVE, all-zero elsewhere; never two bits set.
- dec_count: +1 on each accept, holds at 2^CNT_W-1. clear has priority: clear and accept in same cycle yields 0.
- Reset values: state IDLE, out 0, busy 0, done 0, dec_count 0, latched code 0, counter 0; in_ready 0 while rst_n low.
- Reset mid-pulse: out drops to 0 asynchronously; no done pulse; in-flight code is discarded and not re-issued.

## Timing
- Accept at edge T → out valid from cycle T+1 through T+PULSE_W (PULSE_W cycles).
- done high during cycle T+PULSE_W only.
- in_ready returns high in cycle T+PULSE_W+GAP_W+1; back-to-back accept period = PULSE_W+GAP_W+1 cycles.
- With GAP_W=0, out falls and in_ready rises in the same cycle; out never asserts the next line in the cycle of the following accept.
- dec_count updates on the edge of acceptance (visible T+1).
- All outputs registered except in_ready (decoded from state register and rst_n).

## Structure
- Shared package decoder_pkg: state typedef (IDLE/ACTIVE/GAP, 2-bit encoding), LINES=8, CODE_W=3 constants.
- Sub-module decoder_3x8: purely combinational 3-bit → 8-bit one-hot core with enable; the sequencer instantiates it with enable = (state==ACTIVE).
- Pulse/gap counter width = clog2(max(PULSE_W,GAP_W,2)).

## Test plan
- Reset then code=5, in_valid 1 cycle, PULSE_W=4, GAP_W=1 → out=8'b0010_0000 for exactly 4 cycles, done in 4th, in_ready high 6 cycles after accept, dec_count=1.
- Sweep codes 0..7 back-to-back with in_valid held high → each out[i] pulses in order, one-hot, no overlap, period 6 cycles, dec_count=8.
- GAP_W=0, PULSE_W=1, continuous valid codes 3,6 → out=8'h08 one cycle, then 8'h40 two cycles later, never 8'h48.
- Change code from 2 to 7 during ACTIVE → out stays 8'h04; code 7 not counted until in_ready and valid coincide.
- CNT_W=2, accept 5 codes → dec_count saturates at 3; assert clear concurrently with an accept → dec_count=0.
- Drop rst_n mid-ACTIVE → out=0 immediately, in_ready=0 during reset, no done; after release in_ready=1 and dec_count=0.
